// File: rtl/seven_segment_scan.sv
// seven_segment_scan: time-multiplexed driver for NUM_DIGITS common-anode
// 7-segment digits sharing one active-low segment bus. Each digit shows one
// hex nibble. New values are staged on `load` and committed to the display
// only at a frame boundary, which is acknowledged by a one-clock `loaded`
// pulse. Individual digits can blink. Every dwell starts with a few all-off
// clocks so that a previous digit cannot ghost onto the next one.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// Digit 0 always displays.
module seven_segment_scan #(
  parameter int NUM_DIGITS   = 2,
  parameter int SCAN_DIV     = 5,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_BIT    = 12
) (
  input  logic                    int_osc,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    load,
  output logic                    loaded,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_DIV-1:0] PRESC_MAX = '1;
  localparam logic [SCAN_DIV-1:0] BLANK_END = SCAN_DIV'(BLANK_CYCLES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [SCAN_DIV-1:0]     presc_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [0:0]              state_p0;
  logic [BLINK_BIT:0]      blink_ctr;
  logic [4*NUM_DIGITS-1:0] staging_val, shadow_val;
  logic [NUM_DIGITS-1:0]   staging_blink, shadow_blink;
  logic                    pending;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    cur_blink, cur_lz, dark;
  logic [NUM_DIGITS-1:0]   anode_nxt, anode_p1;
  logic [6:0]              seg_nxt, seg_p1;
  logic                    loaded_p1;
  logic                    wrap, frame_end;

  // Active-low hex glyphs for the {g,f,e,d,c,b,a} bus.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign wrap      = (presc_p0 == PRESC_MAX);
  assign frame_end = wrap && (idx_p0 == LAST_IDX);

  // ---- stage p0: scan position (prescaler, digit index, dwell phase) ----
  // Prescaler paces each dwell; the digit index advances when it wraps.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      presc_p0 <= '0;
      idx_p0   <= '0;
    end else begin
      presc_p0 <= presc_p0 + SCAN_DIV'(1);
      if (wrap) idx_p0 <= (idx_p0 == LAST_IDX) ? '0 : idx_p0 + IDX_W'(1);
    end
  end

  // Dwell FSM: blank for the first BLANK_CYCLES clocks, then drive until wrap.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset)                                          state_p0 <= ST_BLANK;
    else if (BLANK_CYCLES == 0)                         state_p0 <= ST_DRIVE;
    else if (state_p0 == ST_BLANK && presc_p0 == BLANK_END) state_p0 <= ST_DRIVE;
    else if (state_p0 == ST_DRIVE && wrap)              state_p0 <= ST_BLANK;
  end

  // Free-running blink phase counter; a load does not disturb it.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) blink_ctr <= '0;
    else       blink_ctr <= blink_ctr + (BLINK_BIT+1)'(1);
  end

  // Staging/shadow handshake. A load that lands on the commit clock stays
  // pending, so the commit uses the older staging and the next frame commits again.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      staging_val   <= '0;
      staging_blink <= '0;
      shadow_val    <= '0;
      shadow_blink  <= '0;
      pending       <= 1'b0;
      loaded_p1     <= 1'b0;
    end else begin
      loaded_p1 <= frame_end && pending;
      if (frame_end && pending) begin
        shadow_val   <= staging_val;
        shadow_blink <= staging_blink;
      end
      if (load) begin
        staging_val   <= value;
        staging_blink <= blink_en;
        pending       <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    logic all_zero;
    lz_blank = '0;
    all_zero = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      all_zero = all_zero && (shadow_val[4*d +: 4] == 4'h0);
      if (d != 0) lz_blank[d] = all_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Select the nibble and per-digit flags for the digit under scan.
  always_comb begin
    cur_nib   = 4'h0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_p0 == IDX_W'(d)) begin
        cur_nib   = shadow_val[4*d +: 4];
        cur_blink = shadow_blink[d];
        cur_lz    = lz_blank[d];
      end
    end
  end

  // Build the next pin values; any dark condition turns everything off.
  always_comb begin
    dark      = (state_p0 == ST_BLANK) || (cur_blink && blink_ctr[BLINK_BIT]) || cur_lz;
    anode_nxt = dark ? '1 : ~(NUM_DIGITS'(1) << idx_p0);
    seg_nxt   = dark ? 7'h7F : hex7(cur_nib);
  end

  // ---- stage p1: registered pins, glitch-free and one clock behind p0 ----
  // Output register; reset forces all digits off immediately.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      anode_p1 <= '1;
      seg_p1   <= 7'h7F;
    end else begin
      anode_p1 <= anode_nxt;
      seg_p1   <= seg_nxt;
    end
  end

  assign anode  = anode_p1;
  assign seg    = seg_p1;
  assign loaded = loaded_p1;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan with NUM_DIGITS=2, SCAN_DIV=3,
// BLANK_CYCLES=2, BLINK_BIT=5. The variable k counts clock edges since the
// last reset release. The pins seen after edge k reflect the scan position
// that held before that edge: prescaler (k-1)%8 and digit ((k-1)/8)%2.
module tb_seven_segment_scan;

  logic       int_osc;
  logic       reset;
  logic [7:0] value;
  logic [1:0] blink_en;
  logic       load;
  logic       loaded;
  logic [1:0] anode;
  logic [6:0] seg;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  seven_segment_scan #(
    .NUM_DIGITS(2), .SCAN_DIV(3), .BLANK_CYCLES(2), .BLINK_BIT(5)
  ) dut (
    .int_osc(int_osc), .reset(reset), .value(value), .blink_en(blink_en),
    .load(load), .loaded(loaded), .anode(anode), .seg(seg)
  );

  initial int_osc = 1'b0;
  always #5 int_osc = ~int_osc;

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: glyph = 7'h40;  1: glyph = 7'h79;  2: glyph = 7'h24;  3: glyph = 7'h30;
      4: glyph = 7'h19;  5: glyph = 7'h12;  6: glyph = 7'h02;  7: glyph = 7'h78;
      8: glyph = 7'h00;  9: glyph = 7'h10; 10: glyph = 7'h08; 11: glyph = 7'h03;
     12: glyph = 7'h46; 13: glyph = 7'h21; 14: glyph = 7'h06; default: glyph = 7'h0E;
    endcase
  endfunction

  // Expected {anode, seg} after edge kk for digit glyphs s0/s1; dark1 turns digit 1 off.
  function automatic logic [8:0] exp_out(input int kk, input logic [6:0] s0,
                                         input logic [6:0] s1, input logic dark1);
    if (((kk - 1) % 8) < 2)          exp_out = {2'b11, 7'h7F};
    else if (((kk - 1) / 8) % 2 == 0) exp_out = {2'b10, s0};
    else if (dark1)                   exp_out = {2'b11, 7'h7F};
    else                              exp_out = {2'b01, s1};
  endfunction

  task automatic tick();
    @(posedge int_osc);
    #1;
    k++;
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; value = 8'h00; blink_en = 2'b00;
    @(posedge int_osc);
    #1;
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; value = 8'h00; blink_en = 2'b00;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({anode, seg, loaded} !== {2'b11, 7'h7F, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_initial got an=%b seg=%h ld=%b want an=11 seg=7f ld=0", anode, seg, loaded);
    end
    @(posedge int_osc); #1; reset = 1'b0; k = 0;
    while (k < 5) tick();
    n_checks++;
    if ({anode, seg} !== {2'b10, 7'h40}) begin
      n_fail++;
      $display("FAIL reset_pre_drive got an=%b seg=%h want an=10 seg=40", anode, seg);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({anode, seg, loaded} !== {2'b11, 7'h7F, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_drive got an=%b seg=%h ld=%b want an=11 seg=7f ld=0", anode, seg, loaded);
    end
    @(posedge int_osc); #1; reset = 1'b0; k = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++;
      if ({anode, seg} !== ((c == 3) ? {2'b10, 7'h40} : {2'b11, 7'h7F})) begin
        n_fail++;
        $display("FAIL reset_restart k=%0d got an=%b seg=%h want %s", k, anode, seg,
                 (c == 3) ? "an=10 seg=40" : "an=11 seg=7f");
      end
    end
  endtask

  task automatic test_load_frame();
    int pulses;
    int pulse_k;
    logic [8:0] e;
    pulses = 0; pulse_k = -1;
    do_reset();
    value = 8'h3A; load = 1'b1; tick(); load = 1'b0; value = 8'h00;
    while (k < 40) begin
      tick();
      if (loaded === 1'b1) begin pulses++; pulse_k = k; end
      if (k <= 16) e = exp_out(k, 7'h40, 7'h40, LZB);
      else         e = exp_out(k, 7'h08, 7'h30, 1'b0);
      n_checks++;
      if ({anode, seg} !== e) begin
        n_fail++;
        $display("FAIL load3a_disp k=%0d got an=%b seg=%h want an=%b seg=%h", k, anode, seg, e[8:7], e[6:0]);
      end
    end
    n_checks++;
    if (pulses !== 1 || pulse_k !== 16) begin
      n_fail++;
      $display("FAIL load3a_loaded got pulses=%0d at k=%0d want pulses=1 at k=16", pulses, pulse_k);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int ones_seen;
    logic [8:0] e;
    pulses = 0; ones_seen = 0;
    do_reset();
    value = 8'h11; load = 1'b1; tick(); load = 1'b0;
    while (k < 5) tick();
    value = 8'h22; load = 1'b1; tick(); load = 1'b0; value = 8'h00;
    while (k < 48) begin
      tick();
      if (loaded === 1'b1) pulses++;
      if (seg === 7'h79) ones_seen++;
      if (k >= 17) begin
        e = exp_out(k, 7'h24, 7'h24, 1'b0);
        n_checks++;
        if ({anode, seg} !== e) begin
          n_fail++;
          $display("FAIL b2b_disp k=%0d got an=%b seg=%h want an=%b seg=%h", k, anode, seg, e[8:7], e[6:0]);
        end
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL b2b_loaded got pulses=%0d want 1", pulses);
    end
    n_checks++;
    if (ones_seen !== 0) begin
      n_fail++;
      $display("FAIL b2b_stale got %0d clocks showing 1 want 0", ones_seen);
    end
  endtask

  task automatic test_load_on_commit();
    int pulses;
    int last_k;
    logic [8:0] e;
    pulses = 0; last_k = -1;
    do_reset();
    value = 8'h12; load = 1'b1; tick(); load = 1'b0;
    while (k < 15) tick();
    value = 8'h5C; load = 1'b1; tick(); load = 1'b0; value = 8'h00;
    n_checks++;
    if (loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_first_pulse k=%0d got loaded=%b want 1", k, loaded);
    end
    while (k < 48) begin
      tick();
      if (loaded === 1'b1) begin pulses++; last_k = k; end
      if (k <= 32) e = exp_out(k, 7'h24, 7'h79, 1'b0);
      else         e = exp_out(k, 7'h46, 7'h12, 1'b0);
      n_checks++;
      if ({anode, seg} !== e) begin
        n_fail++;
        $display("FAIL commit_disp k=%0d got an=%b seg=%h want an=%b seg=%h", k, anode, seg, e[8:7], e[6:0]);
      end
    end
    n_checks++;
    if (pulses !== 1 || last_k !== 32) begin
      n_fail++;
      $display("FAIL commit_second_pulse got pulses=%0d at k=%0d want 1 at k=32", pulses, last_k);
    end
  endtask

  task automatic test_blink();
    logic [8:0] e;
    do_reset();
    value = 8'h88; blink_en = 2'b10; load = 1'b1; tick(); load = 1'b0; blink_en = 2'b00;
    while (k < 16) tick();
    while (k < 200) begin
      tick();
      e = exp_out(k, 7'h00, 7'h00, ((k - 1) % 64) >= 32);
      n_checks++;
      if ({anode, seg} !== e) begin
        n_fail++;
        $display("FAIL blink k=%0d got an=%b seg=%h want an=%b seg=%h", k, anode, seg, e[8:7], e[6:0]);
      end
    end
  endtask

  task automatic test_ghost();
    do_reset();
    while (k < 1000) begin
      if (k % 50 == 3) begin
        value = 8'(k * 37); blink_en = 2'(k); load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      n_checks++;
      if ($countones(~anode) > 1) begin
        n_fail++;
        $display("FAIL ghost_anodes k=%0d got an=%b want at most one low", k, anode);
      end
      if (anode === 2'b11) begin
        n_checks++;
        if (seg !== 7'h7F) begin
          n_fail++;
          $display("FAIL ghost_seg k=%0d got seg=%h want 7f with anodes off", k, seg);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_hex_map();
    for (int n = 0; n < 16; n += 2) begin
      do_reset();
      value = {4'(n + 1), 4'(n)}; load = 1'b1; tick(); load = 1'b0;
      while (k < 19) tick();
      n_checks++;
      if ({anode, seg} !== {2'b10, glyph(n)}) begin
        n_fail++;
        $display("FAIL hex_%0h got an=%b seg=%h want an=10 seg=%h", n, anode, seg, glyph(n));
      end
      while (k < 27) tick();
      n_checks++;
      if ({anode, seg} !== {2'b01, glyph(n + 1)}) begin
        n_fail++;
        $display("FAIL hex_%0h got an=%b seg=%h want an=01 seg=%h", n + 1, anode, seg, glyph(n + 1));
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [8:0] e;
    logic [7:0] vals [2];
    vals[0] = 8'h00; vals[1] = 8'h07;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      value = vals[v]; load = 1'b1; tick(); load = 1'b0;
      while (k < 16) tick();
      while (k < 32) begin
        tick();
        e = exp_out(k, (v == 0) ? 7'h40 : 7'h78, 7'h40, LZB);
        n_checks++;
        if ({anode, seg} !== e) begin
          n_fail++;
          $display("FAIL lzb_%0h k=%0d got an=%b seg=%h want an=%b seg=%h", vals[v], k, anode, seg, e[8:7], e[6:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_frame();
    test_back_to_back();
    test_load_on_commit();
    test_blink();
    test_ghost();
    test_hex_map();
    test_leading_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
